cp0_exc_commit: RTL and testbench
=================================

# cp0_exc_commit

Coprocessor-0 register block that consumes the exception decision made in MEM1 and commits it architecturally. It holds Status, Cause, EPC, BadVAddr, Count, Compare and EBase. On an exception or ERET it updates these registers, and it serves MTC0/MFC0 accesses. It also drives the Status, Cause and EBase fields that the MEM1 exception resolver reads back, closing that loop.

## Interface
Parameters:
- `EBASE_RST`, 32'h8000_0000, reset value of EBase.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-low reset.
- `MEM_ExcType`  in  5  resolved exception code (`EX_*` encoding, incl. `EX_None`/`EX_Refetch`/`EX_Eret`).
- `MEM_PC`  in  32  PC of the committing instruction.
- `MEM_IsInDelaySlot`  in  1  committing instruction sits in a branch delay slot.
- `MEM_BadVAddr`  in  32  faulting data address for MEM-stage address/TLB faults.
- `MEM_Stall`  in  1  MEM1 stalled; no commit this cycle.
- `CP0_We`  in  1  MTC0 write enable.
- `CP0_Waddr`  in  5  MTC0 register number.
- `CP0_Wsel`  in  3  MTC0 select.
- `CP0_Wdata`  in  32  MTC0 data.
- `CP0_Raddr`  in  5  MFC0 register number.
- `CP0_Rsel`  in  3  MFC0 select.
- `CP0_Rdata`  out  32  MFC0 data, combinational.
- `Ext_Int`  in  6  external hardware interrupts (HW5..HW0).
- `CP0_Status_BEV`  out  1  Status[22].
- `CP0_Status_IM7_0`  out  8  Status[15:8].
- `CP0_Status_EXL`  out  1  Status[1].
- `CP0_Status_IE`  out  1  Status[0].
- `CP0_Cause_IP7_2`  out  6  Cause[15:10].
- `CP0_Cause_IP1_0`  out  2  Cause[9:8].
- `CP0_Ebase`  out  32  EBase.
- `CP0_EPC`  out  32  EPC, the ERET target.

## Operation
- **Commit conditions.**
  - Commit = `!MEM_Stall`.
  - Exception commit = commit && `MEM_ExcType` ∉ {`EX_None`, `EX_Refetch`, `EX_Eret`}.
  - Eret commit = commit && `EX_Eret`.
- **Exception commit.**
  - EPC and Cause.BD are updated only if EXL==0:
    - EPC ← `MEM_IsInDelaySlot` ? `MEM_PC`−4 : `MEM_PC`.
    - Cause.BD ← `MEM_IsInDelaySlot`.
  - If EXL==1, EPC and BD are held.
  - Always: EXL←1, and Cause.ExcCode ← mapped code (see next bullet).
- **ExcCode mapping.** Int 0, Mod 1, TLBL 2 (IF/Rd refill/invalid, AdEL-fetch excluded), TLBS 3, AdEL 4 (IF address error and Rd address error), AdES 5, Sys 8, Bp 9, RI 10, CpU 11, Ov 12, Tr 13.
- **BadVAddr.**
  - IF address error or IF TLB fault → `MEM_PC`.
  - MEM Rd/Wr address error, MEM TLB fault, TLBModified → `MEM_BadVAddr`.
  - All other exceptions → unchanged.
- **Eret commit.** EXL←0; nothing else changes.
- **MTC0 writable fields.**
  - Status: IM, EXL, IE.
  - Cause: IP1_0.
  - EPC, Count, Compare.
  - EBase[29:12].
  - BadVAddr is read-only.
  - Writing Compare clears Cause.TI.
  - Writes to unimplemented registers are dropped.
- **MTC0 vs. commit.** `CP0_We` is ignored in any cycle with an exception or ERET commit, because the committing instruction has been flushed.
- **Interrupt pending.**
  - Cause.IP7_2 ← {`Ext_Int[5]` | TI, `Ext_Int[4:0]`}, registered every cycle.
  - When the timer is compiled out, IP7 ← `Ext_Int[5]`.
- **MFC0.**
  - Unimplemented addresses read 0.
  - Reads return the current register value, with no bypass of a same-cycle write.

## Timing
- All register updates take effect at the next `clk` edge and are visible on outputs one cycle after commit.
- `CP0_Rdata` is combinational.
- Reset values:
  - Status = 32'h0040_0000 (BEV=1, EXL=0, IE=0, IM=0).
  - Cause = 0.
  - EPC = 0, BadVAddr = 0, Count = 0, Compare = 0.
  - EBase = `EBASE_RST`.
  - All outputs follow these values.
- Reset asserted mid-operation overrides any pending commit or write in that cycle.
- Count increments once every two cycles via an internal toggle, which resets to 0. Count wraps 32'hFFFF_FFFF→0.
- TI sets in the cycle after Count==Compare becomes true.
- MTC0 to Count/Compare in the same cycle as the increment: the written value wins.

## Configuration
- `CP0_TIMER_INT_EN` defined: Count/Compare timer and Cause.TI are implemented, and TI is ORed into IP7.
- Undefined:
  - Count and Compare read 0 and ignore writes.
  - TI is 0.
  - IP7 = `Ext_Int[5]`.

## Structure
- Shared CPU package/defines gain:
  - CP0 register number/select constants.
  - Architectural ExcCode constants.
  - Status/Cause field bit positions.
- `EX_*` codes stay in the existing defines.
- Sub-module: `cp0_timer` (Count, Compare, toggle, TI), instantiated only under `CP0_TIMER_INT_EN`.

## Test plan
- Reset → Status=0x0040_0000, EBase=0x8000_0000, all other registers 0, `CP0_Rdata` of reg 12 = 0x0040_0000.
- `EX_Syscall`, PC=0xBFC0_0100, delay slot=1, EXL=0 → EPC=0xBFC0_00FC, Cause.BD=1, ExcCode=8, EXL=1.
- Second exception `EX_Overflow` while EXL=1 → EPC unchanged, ExcCode=12.
- `EX_RdWrongAddressinMEM`, BadVAddr=0x8000_0003 → BadVAddr=0x8000_0003, ExcCode=4. Then `EX_Eret` → EXL=0.
- MTC0 Compare=10, Count=0 → IP7=1 about 21 cycles later. MTC0 Compare → IP7=0 next cycle.
- `MEM_Stall`=1 with `EX_Break` → no register change. Exception and `CP0_We` (EPC=0x1234) in same cycle → EPC = exception value.

Source files
------------

// File: rtl/cp0_exc_commit_pkg.sv
// -----------------------------------------------------------------------------
// cp0_exc_commit_pkg
//   Shared CPU constants used by the CP0 commit block and its timer:
//   - EX_* resolved exception codes produced by the MEM1 exception resolver
//   - CP0 register numbers and selects
//   - architectural ExcCode values
//   - Status / Cause field bit positions
//   - helper functions that classify an EX_* code
// -----------------------------------------------------------------------------
package cp0_exc_commit_pkg;

  // Resolved exception codes from MEM1.
  localparam logic [4:0] EX_None                = 5'd0;
  localparam logic [4:0] EX_Interrupt           = 5'd1;
  localparam logic [4:0] EX_WrongAddressinIF    = 5'd2;
  localparam logic [4:0] EX_TLBRefillinIF       = 5'd3;
  localparam logic [4:0] EX_TLBInvalidinIF      = 5'd4;
  localparam logic [4:0] EX_Syscall             = 5'd5;
  localparam logic [4:0] EX_Break               = 5'd6;
  localparam logic [4:0] EX_RI                  = 5'd7;
  localparam logic [4:0] EX_CpU                 = 5'd8;
  localparam logic [4:0] EX_Overflow            = 5'd9;
  localparam logic [4:0] EX_Trap                = 5'd10;
  localparam logic [4:0] EX_RdWrongAddressinMEM = 5'd11;
  localparam logic [4:0] EX_WrWrongAddressinMEM = 5'd12;
  localparam logic [4:0] EX_TLBRefillinMEMRd    = 5'd13;
  localparam logic [4:0] EX_TLBInvalidinMEMRd   = 5'd14;
  localparam logic [4:0] EX_TLBRefillinMEMWr    = 5'd15;
  localparam logic [4:0] EX_TLBInvalidinMEMWr   = 5'd16;
  localparam logic [4:0] EX_TLBModified         = 5'd17;
  localparam logic [4:0] EX_Refetch             = 5'd18;
  localparam logic [4:0] EX_Eret                = 5'd19;

  // CP0 register numbers / selects.
  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;
  localparam logic [4:0] CP0_REG_EBASE    = 5'd15;
  localparam logic [2:0] CP0_SEL_0        = 3'd0;
  localparam logic [2:0] CP0_SEL_EBASE    = 3'd1;

  // Architectural ExcCode values.
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_CPU  = 5'd11;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  // Status / Cause field positions.
  localparam int STATUS_BEV   = 22;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IE    = 0;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_EXC_LO = 2;

  // True for codes that commit as a real exception.
  function automatic logic is_exception(input logic [4:0] ex);
    return (ex != EX_None) && (ex != EX_Refetch) && (ex != EX_Eret);
  endfunction

  // EX_* code to architectural ExcCode.
  function automatic logic [4:0] exc_code_map(input logic [4:0] ex);
    logic [4:0] code;
    case (ex)
      EX_Interrupt:           code = EXC_INT;
      EX_TLBModified:         code = EXC_MOD;
      EX_TLBRefillinIF,
      EX_TLBInvalidinIF,
      EX_TLBRefillinMEMRd,
      EX_TLBInvalidinMEMRd:   code = EXC_TLBL;
      EX_TLBRefillinMEMWr,
      EX_TLBInvalidinMEMWr:   code = EXC_TLBS;
      EX_WrongAddressinIF,
      EX_RdWrongAddressinMEM: code = EXC_ADEL;
      EX_WrWrongAddressinMEM: code = EXC_ADES;
      EX_Syscall:             code = EXC_SYS;
      EX_Break:               code = EXC_BP;
      EX_RI:                  code = EXC_RI;
      EX_CpU:                 code = EXC_CPU;
      EX_Overflow:            code = EXC_OV;
      EX_Trap:                code = EXC_TR;
      default:                code = EXC_INT;
    endcase
    return code;
  endfunction

  // Fetch-side faults: the faulting address is the PC itself.
  function automatic logic badva_from_pc(input logic [4:0] ex);
    return (ex == EX_WrongAddressinIF) || (ex == EX_TLBRefillinIF) ||
           (ex == EX_TLBInvalidinIF);
  endfunction

  // Data-side faults: the faulting address comes from the MEM stage.
  function automatic logic badva_from_mem(input logic [4:0] ex);
    return (ex == EX_RdWrongAddressinMEM) || (ex == EX_WrWrongAddressinMEM) ||
           (ex == EX_TLBRefillinMEMRd)    || (ex == EX_TLBInvalidinMEMRd)   ||
           (ex == EX_TLBRefillinMEMWr)    || (ex == EX_TLBInvalidinMEMWr)   ||
           (ex == EX_TLBModified);
  endfunction

endpackage

// File: rtl/cp0_exc_commit_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer
//   Count / Compare timer. Count advances once every two clocks through a
//   free-running toggle; TI sets when Count==Compare becomes true and clears
//   on any Compare write. Instantiated by cp0_exc_commit only when
//   CP0_TIMER_INT_EN is defined.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   count_we      MTC0 write to Count (wins over the increment)
//   compare_we    MTC0 write to Compare (clears TI)
//   wdata         MTC0 data
//   count         current Count
//   compare       current Compare
//   ti            current TI
//   ti_next       TI value after the coming edge (lets IP7 track TI exactly)
// -----------------------------------------------------------------------------
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti,
  output logic        ti_next
);

  logic        toggle_q, toggle_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        eq_q, eq_d;
  logic        ti_q, ti_d;

  // Next-state for the timer registers.
  always_comb begin
    toggle_d  = ~toggle_q;
    eq_d      = (count_q == compare_q);
    if (count_we) begin
      count_d = wdata;
    end else if (toggle_q) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
    if (compare_we) begin
      compare_d = wdata;
    end else begin
      compare_d = compare_q;
    end
    // Set only on the rising edge of equality; eq_q resets to 1 so the
    // matching reset values of Count and Compare do not raise TI.
    if (compare_we) begin
      ti_d = 1'b0;
    end else if (eq_d && !eq_q) begin
      ti_d = 1'b1;
    end else begin
      ti_d = ti_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toggle_q  <= 1'b0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      eq_q      <= 1'b1;
      ti_q      <= 1'b0;
    end else begin
      toggle_q  <= toggle_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      eq_q      <= eq_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;
  assign ti_next = ti_d;

endmodule

// File: rtl/cp0_exc_commit.sv
// -----------------------------------------------------------------------------
// cp0_exc_commit
//   CP0 register block: commits the MEM1 exception/ERET decision into Status,
//   Cause, EPC and BadVAddr, serves MTC0/MFC0, and feeds Status/Cause/EBase
//   fields back to the MEM1 exception resolver.
// Optional feature macro: CP0_TIMER_INT_EN (Count/Compare timer and Cause.TI).
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   MEM_ExcType/PC/IsInDelaySlot/BadVAddr/Stall   commit inputs from MEM1
//   CP0_We/Waddr/Wsel/Wdata          MTC0 write port
//   CP0_Raddr/Rsel -> CP0_Rdata      MFC0 read port (combinational)
//   Ext_Int                          external interrupts HW5..HW0
//   CP0_Status_*, CP0_Cause_*, CP0_Ebase, CP0_EPC   register field outputs
// -----------------------------------------------------------------------------
module cp0_exc_commit
  import cp0_exc_commit_pkg::*;
#(
  parameter logic [31:0] EBASE_RST = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  MEM_ExcType,
  input  logic [31:0] MEM_PC,
  input  logic        MEM_IsInDelaySlot,
  input  logic [31:0] MEM_BadVAddr,
  input  logic        MEM_Stall,
  input  logic        CP0_We,
  input  logic [4:0]  CP0_Waddr,
  input  logic [2:0]  CP0_Wsel,
  input  logic [31:0] CP0_Wdata,
  input  logic [4:0]  CP0_Raddr,
  input  logic [2:0]  CP0_Rsel,
  output logic [31:0] CP0_Rdata,
  input  logic [5:0]  Ext_Int,
  output logic        CP0_Status_BEV,
  output logic [7:0]  CP0_Status_IM7_0,
  output logic        CP0_Status_EXL,
  output logic        CP0_Status_IE,
  output logic [5:0]  CP0_Cause_IP7_2,
  output logic [1:0]  CP0_Cause_IP1_0,
  output logic [31:0] CP0_Ebase,
  output logic [31:0] CP0_EPC
);

  logic        exc_commit_s, eret_commit_s, mtc0_s;
  logic        wr_status_s, wr_cause_s, wr_epc_s, wr_ebase_s;
  logic [31:0] count_s, compare_s;
  logic        ti_s, ti_next_s;
  logic [31:0] status_s, cause_s;

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [5:0]  ip7_2_q, ip7_2_d;
  logic [1:0]  ip1_0_q, ip1_0_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [17:0] ebase_q, ebase_d;

  assign exc_commit_s  = !MEM_Stall && is_exception(MEM_ExcType);
  assign eret_commit_s = !MEM_Stall && (MEM_ExcType == EX_Eret);
  // A committing exception/ERET flushes the MTC0 in flight.
  assign mtc0_s        = CP0_We && !exc_commit_s && !eret_commit_s;

  assign wr_status_s = mtc0_s && (CP0_Waddr == CP0_REG_STATUS) && (CP0_Wsel == CP0_SEL_0);
  assign wr_cause_s  = mtc0_s && (CP0_Waddr == CP0_REG_CAUSE)  && (CP0_Wsel == CP0_SEL_0);
  assign wr_epc_s    = mtc0_s && (CP0_Waddr == CP0_REG_EPC)    && (CP0_Wsel == CP0_SEL_0);
  assign wr_ebase_s  = mtc0_s && (CP0_Waddr == CP0_REG_EBASE)  && (CP0_Wsel == CP0_SEL_EBASE);

`ifdef CP0_TIMER_INT_EN
  logic wr_count_s, wr_compare_s;
  assign wr_count_s   = mtc0_s && (CP0_Waddr == CP0_REG_COUNT)   && (CP0_Wsel == CP0_SEL_0);
  assign wr_compare_s = mtc0_s && (CP0_Waddr == CP0_REG_COMPARE) && (CP0_Wsel == CP0_SEL_0);

  cp0_timer u_cp0_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_count_s),
    .compare_we (wr_compare_s),
    .wdata      (CP0_Wdata),
    .count      (count_s),
    .compare    (compare_s),
    .ti         (ti_s),
    .ti_next    (ti_next_s)
  );
`else
  assign count_s   = 32'd0;
  assign compare_s = 32'd0;
  assign ti_s      = 1'b0;
  assign ti_next_s = 1'b0;
`endif

  // Next-state for Status/Cause/EPC/BadVAddr/EBase: commit beats MTC0.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    ip1_0_d    = ip1_0_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    ebase_d    = ebase_q;
    // IP7 uses the post-edge TI so it rises and falls together with Cause.TI.
    ip7_2_d    = {Ext_Int[5] | ti_next_s, Ext_Int[4:0]};

    if (exc_commit_s) begin
      // A nested exception (EXL already set) keeps the original EPC/BD.
      if (!exl_q) begin
        epc_d = MEM_IsInDelaySlot ? (MEM_PC - 32'd4) : MEM_PC;
        bd_d  = MEM_IsInDelaySlot;
      end else begin
        epc_d = epc_q;
        bd_d  = bd_q;
      end
      exl_d      = 1'b1;
      exc_code_d = exc_code_map(MEM_ExcType);
      if (badva_from_pc(MEM_ExcType)) begin
        badvaddr_d = MEM_PC;
      end else if (badva_from_mem(MEM_ExcType)) begin
        badvaddr_d = MEM_BadVAddr;
      end else begin
        badvaddr_d = badvaddr_q;
      end
    end else if (eret_commit_s) begin
      exl_d = 1'b0;
    end else begin
      if (wr_status_s) begin
        im_d  = CP0_Wdata[STATUS_IM_LO +: 8];
        exl_d = CP0_Wdata[STATUS_EXL];
        ie_d  = CP0_Wdata[STATUS_IE];
      end else begin
        im_d  = im_q;
      end
      if (wr_cause_s) begin
        ip1_0_d = CP0_Wdata[CAUSE_IP_LO +: 2];
      end else begin
        ip1_0_d = ip1_0_q;
      end
      if (wr_epc_s) begin
        epc_d = CP0_Wdata;
      end else begin
        epc_d = epc_q;
      end
      if (wr_ebase_s) begin
        ebase_d = CP0_Wdata[29:12];
      end else begin
        ebase_d = ebase_q;
      end
    end
  end

  // Architectural CP0 registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= 5'd0;
      ip7_2_q    <= 6'd0;
      ip1_0_q    <= 2'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      ebase_q    <= EBASE_RST[29:12];
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      ip7_2_q    <= ip7_2_d;
      ip1_0_q    <= ip1_0_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      ebase_q    <= ebase_d;
    end
  end

  // Assemble full Status/Cause words; BEV is hard-wired to 1.
  always_comb begin
    status_s                      = 32'd0;
    status_s[STATUS_BEV]          = 1'b1;
    status_s[STATUS_IM_LO +: 8]   = im_q;
    status_s[STATUS_EXL]          = exl_q;
    status_s[STATUS_IE]           = ie_q;
    cause_s                       = 32'd0;
    cause_s[CAUSE_BD]             = bd_q;
    cause_s[CAUSE_TI]             = ti_s;
    cause_s[CAUSE_IP_LO +: 8]     = {ip7_2_q, ip1_0_q};
    cause_s[CAUSE_EXC_LO +: 5]    = exc_code_q;
  end

  // MFC0 read mux; unimplemented registers read 0.
  always_comb begin
    case ({CP0_Raddr, CP0_Rsel})
      {CP0_REG_BADVADDR, CP0_SEL_0}:   CP0_Rdata = badvaddr_q;
      {CP0_REG_COUNT,    CP0_SEL_0}:   CP0_Rdata = count_s;
      {CP0_REG_COMPARE,  CP0_SEL_0}:   CP0_Rdata = compare_s;
      {CP0_REG_STATUS,   CP0_SEL_0}:   CP0_Rdata = status_s;
      {CP0_REG_CAUSE,    CP0_SEL_0}:   CP0_Rdata = cause_s;
      {CP0_REG_EPC,      CP0_SEL_0}:   CP0_Rdata = epc_q;
      {CP0_REG_EBASE,    CP0_SEL_EBASE}: CP0_Rdata = CP0_Ebase;
      default:                         CP0_Rdata = 32'd0;
    endcase
  end

  assign CP0_Status_BEV   = 1'b1;
  assign CP0_Status_IM7_0 = im_q;
  assign CP0_Status_EXL   = exl_q;
  assign CP0_Status_IE    = ie_q;
  assign CP0_Cause_IP7_2  = ip7_2_q;
  assign CP0_Cause_IP1_0  = ip1_0_q;
  assign CP0_Ebase        = {EBASE_RST[31:30], ebase_q, EBASE_RST[11:0]};
  assign CP0_EPC          = epc_q;

endmodule

// File: tb/tb_cp0_exc_commit.sv
// -----------------------------------------------------------------------------
// tb_cp0_exc_commit
//   Directed self-checking bench for cp0_exc_commit. Inputs change #1 after
//   the rising edge; outputs are sampled #1 (or #2) after the rising edge.
// -----------------------------------------------------------------------------
module tb_cp0_exc_commit;
  import cp0_exc_commit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  MEM_ExcType;
  logic [31:0] MEM_PC;
  logic        MEM_IsInDelaySlot;
  logic [31:0] MEM_BadVAddr;
  logic        MEM_Stall;
  logic        CP0_We;
  logic [4:0]  CP0_Waddr;
  logic [2:0]  CP0_Wsel;
  logic [31:0] CP0_Wdata;
  logic [4:0]  CP0_Raddr;
  logic [2:0]  CP0_Rsel;
  logic [31:0] CP0_Rdata;
  logic [5:0]  Ext_Int;
  logic        CP0_Status_BEV;
  logic [7:0]  CP0_Status_IM7_0;
  logic        CP0_Status_EXL;
  logic        CP0_Status_IE;
  logic [5:0]  CP0_Cause_IP7_2;
  logic [1:0]  CP0_Cause_IP1_0;
  logic [31:0] CP0_Ebase;
  logic [31:0] CP0_EPC;

  int tests_run    = 0;
  int tests_failed = 0;

  cp0_exc_commit #(.EBASE_RST(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .MEM_ExcType(MEM_ExcType), .MEM_PC(MEM_PC), .MEM_IsInDelaySlot(MEM_IsInDelaySlot),
    .MEM_BadVAddr(MEM_BadVAddr), .MEM_Stall(MEM_Stall),
    .CP0_We(CP0_We), .CP0_Waddr(CP0_Waddr), .CP0_Wsel(CP0_Wsel), .CP0_Wdata(CP0_Wdata),
    .CP0_Raddr(CP0_Raddr), .CP0_Rsel(CP0_Rsel), .CP0_Rdata(CP0_Rdata),
    .Ext_Int(Ext_Int),
    .CP0_Status_BEV(CP0_Status_BEV), .CP0_Status_IM7_0(CP0_Status_IM7_0),
    .CP0_Status_EXL(CP0_Status_EXL), .CP0_Status_IE(CP0_Status_IE),
    .CP0_Cause_IP7_2(CP0_Cause_IP7_2), .CP0_Cause_IP1_0(CP0_Cause_IP1_0),
    .CP0_Ebase(CP0_Ebase), .CP0_EPC(CP0_EPC)
  );

  always #5 clk = ~clk;

  // One committing instruction, then back to idle.
  task automatic do_commit(input logic [4:0] ex, input logic [31:0] pc,
                           input logic ds, input logic [31:0] bva);
    MEM_ExcType = ex; MEM_PC = pc; MEM_IsInDelaySlot = ds; MEM_BadVAddr = bva;
    @(posedge clk); #1;
    MEM_ExcType = EX_None; MEM_IsInDelaySlot = 1'b0;
  endtask

  // One MTC0 write.
  task automatic do_mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    CP0_We = 1'b1; CP0_Waddr = a; CP0_Wsel = s; CP0_Wdata = d;
    @(posedge clk); #1;
    CP0_We = 1'b0;
  endtask

  // Combinational MFC0 read.
  task automatic rd(input logic [4:0] a, input logic [2:0] s, output logic [31:0] v);
    CP0_Raddr = a; CP0_Rsel = s; #1; v = CP0_Rdata;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (CP0_Status_BEV !== 1'b1) begin tests_failed++; $display("FAIL reset_bev got %b exp 1", CP0_Status_BEV); end
    tests_run++; if ({CP0_Status_IM7_0, CP0_Status_EXL, CP0_Status_IE} !== 10'd0) begin tests_failed++; $display("FAIL reset_status_fields got %h exp 0", {CP0_Status_IM7_0, CP0_Status_EXL, CP0_Status_IE}); end
    tests_run++; if (CP0_Ebase !== 32'h8000_0000) begin tests_failed++; $display("FAIL reset_ebase got %h exp 80000000", CP0_Ebase); end
    tests_run++; if (CP0_EPC !== 32'd0) begin tests_failed++; $display("FAIL reset_epc got %h exp 0", CP0_EPC); end
    tests_run++; if ({CP0_Cause_IP7_2, CP0_Cause_IP1_0} !== 8'd0) begin tests_failed++; $display("FAIL reset_ip got %h exp 0", {CP0_Cause_IP7_2, CP0_Cause_IP1_0}); end
    rd(CP0_REG_STATUS, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h0040_0000) begin tests_failed++; $display("FAIL reset_rd_status got %h exp 00400000", v); end
    rd(CP0_REG_CAUSE, CP0_SEL_0, v);
    tests_run++; if (v !== 32'd0) begin tests_failed++; $display("FAIL reset_rd_cause got %h exp 0", v); end
    rd(CP0_REG_BADVADDR, CP0_SEL_0, v);
    tests_run++; if (v !== 32'd0) begin tests_failed++; $display("FAIL reset_rd_badva got %h exp 0", v); end
    rd(CP0_REG_COUNT, CP0_SEL_0, v);
    tests_run++; if (v !== 32'd0) begin tests_failed++; $display("FAIL reset_rd_count got %h exp 0", v); end
    rd(CP0_REG_COMPARE, CP0_SEL_0, v);
    tests_run++; if (v !== 32'd0) begin tests_failed++; $display("FAIL reset_rd_compare got %h exp 0", v); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_exception_commit;
    logic [31:0] v;
    do_commit(EX_Syscall, 32'hBFC0_0100, 1'b1, 32'd0);
    tests_run++; if (CP0_EPC !== 32'hBFC0_00FC) begin tests_failed++; $display("FAIL sys_epc got %h exp bfc000fc", CP0_EPC); end
    tests_run++; if (CP0_Status_EXL !== 1'b1) begin tests_failed++; $display("FAIL sys_exl got %b exp 1", CP0_Status_EXL); end
    rd(CP0_REG_CAUSE, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h8000_0020) begin tests_failed++; $display("FAIL sys_cause got %h exp 80000020", v); end
    // Nested exception: EPC and BD held, ExcCode updated.
    do_commit(EX_Overflow, 32'h0000_1000, 1'b0, 32'd0);
    tests_run++; if (CP0_EPC !== 32'hBFC0_00FC) begin tests_failed++; $display("FAIL ov_epc_held got %h exp bfc000fc", CP0_EPC); end
    rd(CP0_REG_CAUSE, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h8000_0030) begin tests_failed++; $display("FAIL ov_cause got %h exp 80000030", v); end
  endtask

  task automatic test_badvaddr_eret;
    logic [31:0] v;
    do_commit(EX_RdWrongAddressinMEM, 32'h0000_2000, 1'b0, 32'h8000_0003);
    rd(CP0_REG_BADVADDR, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h8000_0003) begin tests_failed++; $display("FAIL adel_badva got %h exp 80000003", v); end
    rd(CP0_REG_CAUSE, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h8000_0010) begin tests_failed++; $display("FAIL adel_cause got %h exp 80000010", v); end
    do_commit(EX_Eret, 32'h0, 1'b0, 32'h0);
    tests_run++; if (CP0_Status_EXL !== 1'b0) begin tests_failed++; $display("FAIL eret_exl got %b exp 0", CP0_Status_EXL); end
    tests_run++; if (CP0_EPC !== 32'hBFC0_00FC) begin tests_failed++; $display("FAIL eret_epc got %h exp bfc000fc", CP0_EPC); end
    // Fetch address error: BadVAddr and EPC from PC.
    do_commit(EX_WrongAddressinIF, 32'h0040_0002, 1'b0, 32'hFFFF_FFFF);
    rd(CP0_REG_BADVADDR, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h0040_0002) begin tests_failed++; $display("FAIL ifadel_badva got %h exp 00400002", v); end
    rd(CP0_REG_CAUSE, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h0000_0010) begin tests_failed++; $display("FAIL ifadel_cause got %h exp 00000010", v); end
    tests_run++; if (CP0_EPC !== 32'h0040_0002) begin tests_failed++; $display("FAIL ifadel_epc got %h exp 00400002", CP0_EPC); end
    do_commit(EX_Eret, 32'h0, 1'b0, 32'h0);
    do_commit(EX_TLBModified, 32'h0000_3000, 1'b0, 32'h1234_5000);
    rd(CP0_REG_BADVADDR, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h1234_5000) begin tests_failed++; $display("FAIL mod_badva got %h exp 12345000", v); end
    rd(CP0_REG_CAUSE, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h0000_0004) begin tests_failed++; $display("FAIL mod_cause got %h exp 00000004", v); end
    do_commit(EX_Eret, 32'h0, 1'b0, 32'h0);
    do_commit(EX_TLBRefillinIF, 32'h0000_4000, 1'b0, 32'h5555_5555);
    rd(CP0_REG_BADVADDR, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h0000_4000) begin tests_failed++; $display("FAIL iftlb_badva got %h exp 00004000", v); end
    rd(CP0_REG_CAUSE, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h0000_0008) begin tests_failed++; $display("FAIL iftlb_cause got %h exp 00000008", v); end
    do_commit(EX_Eret, 32'h0, 1'b0, 32'h0);
    // Interrupt leaves BadVAddr alone.
    do_commit(EX_Interrupt, 32'h0000_5000, 1'b1, 32'h6666_6666);
    tests_run++; if (CP0_EPC !== 32'h0000_4FFC) begin tests_failed++; $display("FAIL int_epc got %h exp 00004ffc", CP0_EPC); end
    rd(CP0_REG_BADVADDR, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h0000_4000) begin tests_failed++; $display("FAIL int_badva got %h exp 00004000", v); end
    rd(CP0_REG_CAUSE, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h8000_0000) begin tests_failed++; $display("FAIL int_cause got %h exp 80000000", v); end
    do_commit(EX_Eret, 32'h0, 1'b0, 32'h0);
    // Refetch is not an exception.
    do_commit(EX_Refetch, 32'h0000_9000, 1'b0, 32'h0);
    tests_run++; if ({CP0_Status_EXL, CP0_EPC} !== {1'b0, 32'h0000_4FFC}) begin tests_failed++; $display("FAIL refetch got %h exp 0_00004ffc", {CP0_Status_EXL, CP0_EPC}); end
  endtask

  task automatic test_stall_and_we;
    logic [31:0] v;
    MEM_Stall = 1'b1;
    do_commit(EX_Break, 32'h0000_6000, 1'b0, 32'h0);
    MEM_Stall = 1'b0;
    tests_run++; if ({CP0_Status_EXL, CP0_EPC} !== {1'b0, 32'h0000_4FFC}) begin tests_failed++; $display("FAIL stall_hold got %h exp 0_00004ffc", {CP0_Status_EXL, CP0_EPC}); end
    rd(CP0_REG_CAUSE, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h8000_0000) begin tests_failed++; $display("FAIL stall_cause got %h exp 80000000", v); end
    // Exception and MTC0 EPC in the same cycle: exception wins.
    CP0_We = 1'b1; CP0_Waddr = CP0_REG_EPC; CP0_Wsel = CP0_SEL_0; CP0_Wdata = 32'h0000_1234;
    do_commit(EX_Break, 32'h0000_7000, 1'b0, 32'h0);
    CP0_We = 1'b0;
    tests_run++; if (CP0_EPC !== 32'h0000_7000) begin tests_failed++; $display("FAIL exc_vs_we_epc got %h exp 00007000", CP0_EPC); end
    rd(CP0_REG_CAUSE, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h0000_0024) begin tests_failed++; $display("FAIL bp_cause got %h exp 00000024", v); end
    // ERET and MTC0 Status in the same cycle: write dropped.
    CP0_We = 1'b1; CP0_Waddr = CP0_REG_STATUS; CP0_Wsel = CP0_SEL_0; CP0_Wdata = 32'h0000_FF03;
    do_commit(EX_Eret, 32'h0, 1'b0, 32'h0);
    CP0_We = 1'b0;
    rd(CP0_REG_STATUS, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h0040_0000) begin tests_failed++; $display("FAIL eret_vs_we_status got %h exp 00400000", v); end
  endtask

  task automatic test_mtc0;
    logic [31:0] v;
    do_mtc0(CP0_REG_STATUS, CP0_SEL_0, 32'hFFFF_FF03);
    rd(CP0_REG_STATUS, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h0040_FF03) begin tests_failed++; $display("FAIL mtc0_status got %h exp 0040ff03", v); end
    tests_run++; if ({CP0_Status_IM7_0, CP0_Status_EXL, CP0_Status_IE} !== 10'h3FF) begin tests_failed++; $display("FAIL mtc0_status_out got %h exp 3ff", {CP0_Status_IM7_0, CP0_Status_EXL, CP0_Status_IE}); end
    do_mtc0(CP0_REG_STATUS, CP0_SEL_0, 32'h0000_0000);
    // Same-cycle read shows the old value.
    CP0_We = 1'b1; CP0_Waddr = CP0_REG_EPC; CP0_Wsel = CP0_SEL_0; CP0_Wdata = 32'hCAFE_0000;
    rd(CP0_REG_EPC, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h0000_7000) begin tests_failed++; $display("FAIL no_bypass got %h exp 00007000", v); end
    @(posedge clk); #1; CP0_We = 1'b0;
    tests_run++; if (CP0_EPC !== 32'hCAFE_0000) begin tests_failed++; $display("FAIL mtc0_epc got %h exp cafe0000", CP0_EPC); end
    do_mtc0(CP0_REG_CAUSE, CP0_SEL_0, 32'hFFFF_FFFF);
    rd(CP0_REG_CAUSE, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h0000_0324) begin tests_failed++; $display("FAIL mtc0_cause got %h exp 00000324", v); end
    tests_run++; if (CP0_Cause_IP1_0 !== 2'b11) begin tests_failed++; $display("FAIL mtc0_ip10 got %b exp 11", CP0_Cause_IP1_0); end
    do_mtc0(CP0_REG_CAUSE, CP0_SEL_0, 32'h0000_0000);
    do_mtc0(CP0_REG_BADVADDR, CP0_SEL_0, 32'hDEAD_BEEF);
    rd(CP0_REG_BADVADDR, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h0000_4000) begin tests_failed++; $display("FAIL badva_ro got %h exp 00004000", v); end
    do_mtc0(CP0_REG_EBASE, CP0_SEL_0, 32'h0000_0000);
    tests_run++; if (CP0_Ebase !== 32'h8000_0000) begin tests_failed++; $display("FAIL ebase_sel0 got %h exp 80000000", CP0_Ebase); end
    do_mtc0(CP0_REG_EBASE, CP0_SEL_EBASE, 32'hFFFF_FFFF);
    tests_run++; if (CP0_Ebase !== 32'hBFFF_F000) begin tests_failed++; $display("FAIL ebase_wr got %h exp bffff000", CP0_Ebase); end
    rd(CP0_REG_EBASE, CP0_SEL_EBASE, v);
    tests_run++; if (v !== 32'hBFFF_F000) begin tests_failed++; $display("FAIL ebase_rd got %h exp bffff000", v); end
    rd(5'd3, CP0_SEL_0, v);
    tests_run++; if (v !== 32'd0) begin tests_failed++; $display("FAIL unimpl_rd got %h exp 0", v); end
    rd(CP0_REG_EBASE, CP0_SEL_0, v);
    tests_run++; if (v !== 32'd0) begin tests_failed++; $display("FAIL unimpl_sel_rd got %h exp 0", v); end
  endtask

  task automatic test_interrupts;
    logic [31:0] v;
    Ext_Int = 6'b101010;
    @(posedge clk); #1;
    tests_run++; if (CP0_Cause_IP7_2 !== 6'b101010) begin tests_failed++; $display("FAIL ip72 got %b exp 101010", CP0_Cause_IP7_2); end
    rd(CP0_REG_CAUSE, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h0000_A824) begin tests_failed++; $display("FAIL ip72_cause got %h exp 0000a824", v); end
    Ext_Int = 6'b000000;
    @(posedge clk); #1;
    tests_run++; if (CP0_Cause_IP7_2 !== 6'b000000) begin tests_failed++; $display("FAIL ip72_clr got %b exp 000000", CP0_Cause_IP7_2); end
  endtask

`ifdef CP0_TIMER_INT_EN
  task automatic test_timer;
    logic [31:0] v;
    int first;
    do_mtc0(CP0_REG_COUNT, CP0_SEL_0, 32'd0);
    do_mtc0(CP0_REG_COMPARE, CP0_SEL_0, 32'd10);
    rd(CP0_REG_COUNT, CP0_SEL_0, v);
    tests_run++; if (v > 32'd1) begin tests_failed++; $display("FAIL count_wr got %h exp <=1", v); end
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (first == 0 && CP0_Cause_IP7_2[5] === 1'b1) first = i;
    end
    tests_run++; if (first < 17 || first > 24) begin tests_failed++; $display("FAIL timer_ip7 first cycle %0d exp 17..24", first); end
    rd(CP0_REG_CAUSE, CP0_SEL_0, v);
    tests_run++; if (v[30] !== 1'b1) begin tests_failed++; $display("FAIL timer_ti got %b exp 1", v[30]); end
    do_mtc0(CP0_REG_COMPARE, CP0_SEL_0, 32'hFFFF_FFFF);
    tests_run++; if (CP0_Cause_IP7_2[5] !== 1'b0) begin tests_failed++; $display("FAIL timer_ip7_clr got %b exp 0", CP0_Cause_IP7_2[5]); end
    rd(CP0_REG_CAUSE, CP0_SEL_0, v);
    tests_run++; if (v[30] !== 1'b0) begin tests_failed++; $display("FAIL timer_ti_clr got %b exp 0", v[30]); end
  endtask
`else
  task automatic test_no_timer;
    logic [31:0] v;
    do_mtc0(CP0_REG_COUNT, CP0_SEL_0, 32'd5);
    rd(CP0_REG_COUNT, CP0_SEL_0, v);
    tests_run++; if (v !== 32'd0) begin tests_failed++; $display("FAIL notimer_count got %h exp 0", v); end
    do_mtc0(CP0_REG_COMPARE, CP0_SEL_0, 32'd7);
    rd(CP0_REG_COMPARE, CP0_SEL_0, v);
    tests_run++; if (v !== 32'd0) begin tests_failed++; $display("FAIL notimer_compare got %h exp 0", v); end
    Ext_Int = 6'b100000;
    @(posedge clk); #1;
    tests_run++; if (CP0_Cause_IP7_2 !== 6'b100000) begin tests_failed++; $display("FAIL notimer_ip7 got %b exp 100000", CP0_Cause_IP7_2); end
    rd(CP0_REG_CAUSE, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h0000_8024) begin tests_failed++; $display("FAIL notimer_cause got %h exp 00008024", v); end
    Ext_Int = 6'b000000;
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_mid_reset;
    logic [31:0] v;
    MEM_ExcType = EX_Syscall; MEM_PC = 32'h0000_0100; MEM_IsInDelaySlot = 1'b0;
    CP0_We = 1'b1; CP0_Waddr = CP0_REG_STATUS; CP0_Wsel = CP0_SEL_0; CP0_Wdata = 32'h0000_FF01;
    #2; rst = 1'b0;
    @(posedge clk); #1;
    MEM_ExcType = EX_None; CP0_We = 1'b0;
    tests_run++; if ({CP0_Status_EXL, CP0_EPC} !== 33'd0) begin tests_failed++; $display("FAIL midrst_exl_epc got %h exp 0", {CP0_Status_EXL, CP0_EPC}); end
    tests_run++; if (CP0_Ebase !== 32'h8000_0000) begin tests_failed++; $display("FAIL midrst_ebase got %h exp 80000000", CP0_Ebase); end
    rd(CP0_REG_CAUSE, CP0_SEL_0, v);
    tests_run++; if (v !== 32'd0) begin tests_failed++; $display("FAIL midrst_cause got %h exp 0", v); end
    rd(CP0_REG_STATUS, CP0_SEL_0, v);
    tests_run++; if (v !== 32'h0040_0000) begin tests_failed++; $display("FAIL midrst_status got %h exp 00400000", v); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    MEM_ExcType = EX_None; MEM_PC = 32'd0; MEM_IsInDelaySlot = 1'b0; MEM_BadVAddr = 32'd0;
    MEM_Stall = 1'b0; CP0_We = 1'b0; CP0_Waddr = 5'd0; CP0_Wsel = 3'd0; CP0_Wdata = 32'd0;
    CP0_Raddr = 5'd0; CP0_Rsel = 3'd0; Ext_Int = 6'd0;
    #1;
    test_reset();
    test_exception_commit();
    test_badvaddr_eret();
    test_stall_and_we();
    test_mtc0();
    test_interrupts();
`ifdef CP0_TIMER_INT_EN
    test_timer();
`else
    test_no_timer();
`endif
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
